// File: rtl/adc_capture_ctrl.sv
// ADC frame capture: serialises 4-channel frames into tagged FIFO words, issues
// PSRAM write-burst addresses, latches a pre-trigger replay base and counts drops.
module adc_capture_ctrl #(
    parameter int ADDR_W      = 25,
    parameter int BURST_BYTES = 16,
    parameter int PRE_SAMPLES = 64,
    parameter bit TAG_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [11:0]       ad_a0,
    input  logic [11:0]       ad_a1,
    input  logic [11:0]       ad_b0,
    input  logic [11:0]       ad_b1,
    input  logic              ad_strobe,
    input  logic              psram_ready,
    input  logic              fifo_afull,
    input  logic              fifo_almost_empty,
    output logic              fifo_we,
    output logic [15:0]       fifo_d,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    input  logic              trig_in,
    input  logic              trig_clr,
    output logic [ADDR_W-1:0] base_addr,
    output logic              trig_seen,
    output logic [15:0]       overflow_cnt
);

    localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BYTES);
    localparam logic [ADDR_W-1:0] PRE_BYTES = ADDR_W'(PRE_SAMPLES * 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_W1   = 3'd2,
        S_W2   = 3'd3,
        S_W3   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [11:0]       r_hold [4];
    logic [15:0]       r_ovf;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_trig_d;
    logic              r_trig_seen;
    logic [ADDR_W-1:0] r_base;

    logic              w_admit_window;
    logic              w_accept;
    logic              w_drop;
    logic              w_hs;
    logic              w_rise;
    logic [1:0]        w_ch;
    logic [11:0]       w_sample;

    // A new frame may start only when the previous one is emitting its last word.
    assign w_admit_window = (r_state == S_IDLE) || (r_state == S_W3);
    assign w_accept = ad_strobe & psram_ready & ~fifo_afull & w_admit_window;
    assign w_drop   = ad_strobe & psram_ready & (fifo_afull | ~w_admit_window);
    assign w_hs     = r_awvalid & awready;
    assign w_rise   = trig_in & ~r_trig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = w_accept ? S_W0 : S_IDLE;
            S_W0:    w_state_next = S_W1;
            S_W1:    w_state_next = S_W2;
            S_W2:    w_state_next = S_W3;
            S_W3:    w_state_next = w_accept ? S_W0 : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_we  = 1'b0;
        w_ch     = 2'd0;
        w_sample = 12'd0;
        case (r_state)
            S_W0:    begin fifo_we = 1'b1; w_ch = 2'd0; w_sample = r_hold[0]; end
            S_W1:    begin fifo_we = 1'b1; w_ch = 2'd1; w_sample = r_hold[1]; end
            S_W2:    begin fifo_we = 1'b1; w_ch = 2'd2; w_sample = r_hold[2]; end
            S_W3:    begin fifo_we = 1'b1; w_ch = 2'd3; w_sample = r_hold[3]; end
            default: begin fifo_we = 1'b0; w_ch = 2'd0; w_sample = 12'd0; end
        endcase
        if (TAG_EN) begin
            fifo_d = {w_ch, 2'b00, w_sample};
        end else begin
            fifo_d = {4'h0, w_sample};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold[0] <= 12'd0;
            r_hold[1] <= 12'd0;
            r_hold[2] <= 12'd0;
            r_hold[3] <= 12'd0;
        end else if (w_accept) begin
            r_hold[0] <= ad_a0;
            r_hold[1] <= ad_a1;
            r_hold[2] <= ad_b0;
            r_hold[3] <= ad_b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 16'd0;
        end else if (w_drop && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

    // One-cycle bubble after each handshake lets the FIFO level catch up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
        end else begin
            r_awvalid <= w_hs ? 1'b0 : (~fifo_almost_empty & psram_ready);
            if (w_hs) begin
                r_awaddr <= r_awaddr + BURST_INC;
            end
        end
    end

    // Re-arm takes priority over a simultaneous trigger edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_d    <= 1'b0;
            r_trig_seen <= 1'b0;
            r_base      <= '0;
        end else begin
            r_trig_d <= trig_in;
            if (trig_clr) begin
                r_trig_seen <= 1'b0;
            end else if (!r_trig_seen && w_rise) begin
                r_trig_seen <= 1'b1;
                r_base      <= r_awaddr - PRE_BYTES;
            end
        end
    end

    assign awvalid      = r_awvalid;
    assign awaddr       = r_awaddr;
    assign base_addr    = r_base;
    assign trig_seen    = r_trig_seen;
    assign overflow_cnt = r_ovf;

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sits between the blaster ADC front end and the 512x16 PSRAM write FIFO and the psram_ctrl AXI write-address port.
- Serialises each 4-channel ADC frame into tagged 16-bit FIFO words and issues 16-byte write bursts at an incrementing PSRAM address.
- Latches a pre-trigger base address on a trigger edge for the HDMI replay path.
- Counts dropped frames.

Parameters:
ADDR_W, 25, PSRAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
BURST_BYTES, 16, address increment per accepted write burst (8 words).
PRE_SAMPLES, 64, frames of history kept before the trigger; each frame is 8 bytes.
TAG_EN, 1, 1 = word[15:14] carries the channel index; 0 = upper nibble is zero.

Ports:
clk  in  1  48 MHz ADC-domain clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
ad_a0, ad_a1, ad_b0, ad_b1  in  12 each  ADC samples; valid in the ad_strobe cycle only.
ad_strobe  in  1  one-cycle frame-valid pulse.
psram_ready  in  1  controller initialised; capture is gated off while low.
fifo_afull  in  1  FIFO has fewer than 4 free entries.
fifo_almost_empty  in  1  FIFO holds fewer than 8 words.
fifo_we  out  1  FIFO write enable.
fifo_d  out  16  FIFO write data.
awaddr  out  ADDR_W  burst start address.
awvalid  out  1  burst request.
awready  in  1  burst accepted.
trig_in  in  1  trigger level (pwm); synchronous to clk.
trig_clr  in  1  re-arm pulse.
base_addr  out  ADDR_W  replay base address.
trig_seen  out  1  trigger captured, sticky.
overflow_cnt  out  16  dropped-frame count, saturating.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, trigger edge register 0, armed.
- FSM states: IDLE, W0, W1, W2, W3.
- IDLE -> W0 when ad_strobe & psram_ready & !fifo_afull. Samples are latched into a 4x12 holding register in the same cycle.
- W0..W3 each last one cycle and emit fifo_we=1 with a0, a1, b0, b1 in that order. W3 returns to IDLE.
- Latency: first word is written 1 cycle after the strobe; the last word 4 cycles after.
- Back-to-back: W3 -> W0 directly if an accepted strobe arrives in the W3 cycle (admission rules as in IDLE).
- Word format: TAG_EN=1 gives {ch[1:0], 2'b00, sample[11:0]} with ch a0=0, a1=1, b0=2, b1=3. TAG_EN=0 gives {4'h0, sample}.
- fifo_d is 0 whenever fifo_we=0.
- Frames are atomic; no partial frame is ever written.
- Drop cases: a strobe while psram_ready=1 and either (FSM in W0..W2) or fifo_afull=1 drops the frame and increments overflow_cnt, saturating at 16'hFFFF.
- Strobes while psram_ready=0 are ignored and not counted.
- Write-address channel:
  - awvalid is registered: next value = !fifo_almost_empty & psram_ready, except it is forced to 0 in the cycle after any handshake (one-cycle bubble so FIFO level can update).
  - On awvalid & awready, awaddr <= awaddr + BURST_BYTES, wrapping at 2^ADDR_W.
  - awvalid may drop without a handshake when almost_empty asserts.
- Trigger:
  - trig_d is trig_in delayed one clk; rise = trig_in & !trig_d.
  - If armed (trig_seen=0) and rise: base_addr <= awaddr - PRE_SAMPLES*8 (mod 2^ADDR_W) and trig_seen <= 1.
  - Further rises are ignored while trig_seen=1.
  - trig_clr clears trig_seen and keeps base_addr. If trig_clr and rise occur in the same cycle, clr wins and the rise is ignored.
- psram_ready falling mid-frame: the frame in progress still completes. New admissions and awvalid stop the next cycle.
- Reset mid-frame: outputs clear immediately. The partial frame is lost; the FIFO is reset by the same reset.

Test Plan:
- Frame write: after reset with psram_ready=1, strobe a0=12'h123, a1=12'h456, b0=12'h789, b1=12'hABC -> fifo_we high for cycles 1-4, fifo_d = 16'h0123, 16'h4456, 16'h8789, 16'hCABC; overflow_cnt stays 0.
- Drop rules: a strobe 2 cycles after an accepted strobe -> no extra words and overflow_cnt=1. A strobe with fifo_afull=1 -> no words and overflow_cnt=2. A strobe with psram_ready=0 -> no words and overflow_cnt unchanged.
- Burst issue: fifo_almost_empty=0 with awready=1 for 3 handshakes -> awaddr steps 0, 16, 32, 48, and awvalid is low in the cycle after each handshake.
- Address wrap: awaddr preset near the top via 2^21 handshakes (or forced), handshake at awaddr=25'h1FFFFF0 -> awaddr=0.
- Trigger: awaddr=0x400 and trig_in rises -> base_addr=0x200, trig_seen=1. A second rise changes nothing. trig_clr together with a rise -> trig_seen=0 and base_addr stays 0x200. A rise at awaddr=0 -> base_addr=25'h1FFFE00.
- Saturation: 70000 strobes dropped while fifo_afull=1 -> overflow_cnt=16'hFFFF.
